// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a comparator probe and
// recovers the target MSB first. Define SAR_EARLY_EXIT_EN to stop on i_eq.
module sar_search_ctrl #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_gt,
  input  logic                  i_lt,
  input  logic                  i_eq,
  output logic [DATA_WIDTH-1:0] o_probe,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_found,
  output logic                  o_err
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [IW-1:0] TOP_IDX = IW'(DATA_WIDTH - 1);

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t                state, state_n;
  logic [IW-1:0]         idx, idx_n;
  logic [DATA_WIDTH-1:0] probe_n, result_n, res_new;
  logic                  found_n, err_n, onehot;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      o_probe  <= '0;
      o_result <= '0;
      o_found  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      o_probe  <= probe_n;
      o_result <= result_n;
      o_found  <= found_n;
      o_err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    probe_n  = o_probe;
    result_n = o_result;
    found_n  = o_found;
    err_n    = o_err;
    res_new  = o_result;
    onehot   = ({i_gt, i_lt, i_eq} == 3'b100) ||
               ({i_gt, i_lt, i_eq} == 3'b010) ||
               ({i_gt, i_lt, i_eq} == 3'b001);
    case (state)
      IDLE: begin
        probe_n = '0;
        if (i_start) begin
          state_n  = CMP;
          idx_n    = TOP_IDX;
          probe_n  = ONE << TOP_IDX;
          result_n = '0;
          found_n  = 1'b0;
          err_n    = 1'b0;
        end
      end
      CMP: begin
        if (!onehot) begin
          err_n   = 1'b1;
          state_n = DONE;
          probe_n = '0;
        end else begin
          // gt and eq both mean the trial bit belongs in the answer
          res_new  = (i_gt || i_eq) ? o_probe : o_result;
          result_n = res_new;
          if (i_eq) found_n = 1'b1;
          if ((idx == '0) || (EARLY && i_eq)) begin
            state_n = DONE;
            probe_n = '0;
          end else begin
            idx_n   = idx - IW'(1);
            probe_n = res_new | (ONE << idx_n);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        probe_n = '0;
      end
      default: begin
        state_n = IDLE;
        probe_n = '0;
      end
    endcase
  end

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl (DATA_WIDTH=4) with a behavioural comparator.
module tb_sar_search_ctrl;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       gt, lt, eq;
  logic [3:0] probe, result;
  logic       busy, done, found, err;
  logic [3:0] target = 4'd0;
  logic       force0 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // comparator model; force0 injects an illegal all-zero flag set
  always_comb begin
    if (force0) {gt, lt, eq} = 3'b000;
    else begin
      gt = target > probe;
      lt = target < probe;
      eq = target == probe;
    end
  end

  sar_search_ctrl #(.DATA_WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_gt(gt), .i_lt(lt), .i_eq(eq),
    .o_probe(probe), .o_busy(busy), .o_done(done),
    .o_result(result), .o_found(found), .o_err(err)
  );

  typedef struct {
    logic [3:0]  tgt;
    logic [3:0]  res;
    logic        fnd;
    logic [15:0] probes;    // full-length probe sequence, first probe in MSBs
    int          early_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_search(input string tag, input logic [3:0] tgt, input logic [3:0] exp_res,
                            input logic exp_fnd, input logic exp_err, input int exp_lat,
                            input logic [15:0] exp_probes, input bit glitch);
    logic [3:0] got[4];
    int  edges, np;
    bit  finished;
    edges = 0; np = 0; finished = 0;
    target = tgt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = glitch && (k == 1);
      if (k == 0) begin
        chk({tag, " cleared result"}, 16'(result), 16'd0);
        chk({tag, " cleared found"}, 16'(found), 16'd0);
        chk({tag, " cleared err"}, 16'(err), 16'd0);
      end
      if (done) begin
        finished = 1;
        break;
      end
      if (np < 4) got[np] = probe;
      np++;
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
    if (!finished) chk({tag, " timeout"}, 16'd1, 16'd0);
    chk({tag, " latency"}, 16'(edges), 16'(exp_lat));
    chk({tag, " result"}, 16'(result), 16'(exp_res));
    chk({tag, " found"}, 16'(found), 16'(exp_fnd));
    chk({tag, " err"}, 16'(err), 16'(exp_err));
    chk({tag, " probe at done"}, 16'(probe), 16'd0);
    chk({tag, " busy at done"}, 16'(busy), 16'd1);
    for (int i = 0; i < np && i < 4 && i < exp_lat; i++)
      chk({tag, " probe seq"}, 16'(got[i]), 16'(exp_probes[15-4*i -: 4]));
    @(negedge clk);
    chk({tag, " done one cycle"}, 16'(done), 16'd0);
    chk({tag, " idle busy"}, 16'(busy), 16'd0);
    chk({tag, " result held"}, 16'(result), 16'(exp_res));
  endtask

  initial begin
    vecs[0] = '{4'd11, 4'd11, 1'b1, 16'h8CAB, 4};
    vecs[1] = '{4'd8,  4'd8,  1'b1, 16'h8CA9, 1};
    vecs[2] = '{4'd0,  4'd0,  1'b0, 16'h8421, 4};
    vecs[3] = '{4'd15, 4'd15, 1'b1, 16'h8CEF, 4};
    vecs[4] = '{4'd5,  4'd5,  1'b1, 16'h8465, 4};
    vecs[5] = '{4'd12, 4'd12, 1'b1, 16'h8CED, 2};
    vecs[6] = '{4'd6,  4'd6,  1'b1, 16'h8467, 3};

    #1;
    chk("reset probe", 16'(probe), 16'd0);
    chk("reset busy", 16'(busy), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    chk("reset result", 16'(result), 16'd0);
    chk("reset found", 16'(found), 16'd0);
    chk("reset err", 16'(err), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++)
      run_search($sformatf("tgt%0d", vecs[v].tgt), vecs[v].tgt, vecs[v].res, vecs[v].fnd, 1'b0,
                 EARLY ? vecs[v].early_lat : 4, vecs[v].probes, 1'b0);

    // illegal flags on the first compare cycle
    force0 = 1'b1;
    run_search("err", 4'd9, 4'd0, 1'b0, 1'b1, 1, 16'h8000, 1'b0);
    force0 = 1'b0;
    run_search("err clear", 4'd5, 4'd5, 1'b1, 1'b0, EARLY ? 4 : 4, 16'h8465, 1'b0);

    // start pulse mid-search must be ignored
    run_search("glitch", 4'd11, 4'd11, 1'b1, 1'b0, 4, 16'h8CAB, 1'b1);

    // asynchronous reset during the second compare cycle
    target = 4'd11;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst probe", 16'(probe), 16'd0);
    chk("arst busy", 16'(busy), 16'd0);
    chk("arst done", 16'(done), 16'd0);
    chk("arst result", 16'(result), 16'd0);
    chk("arst found", 16'(found), 16'd0);
    chk("arst err", 16'(err), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_search("post reset", 4'd5, 4'd5, 1'b1, 1'b0, 4, 16'h8465, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
Successive-approximation search engine that drives the probe operand of a magnitude comparator and consumes its gt/lt/eq flags. It recovers an unknown DATA_WIDTH-bit target value held on the comparator's other operand, one bit per clock, MSB first. It sits on the far side of the comparator interface as the comparator's consumer and controller. Typical use is threshold or ADC-style SAR search.

Parameters:
DATA_WIDTH, 4, width of the probe, the target and the result.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  start a search; sampled only in IDLE.
i_gt  input  1  comparator flag: target > o_probe.
i_lt  input  1  comparator flag: target < o_probe.
i_eq  input  1  comparator flag: target == o_probe.
o_probe  output  DATA_WIDTH  registered value driven to the comparator's probe operand.
o_busy  output  1  high in CMP and DONE.
o_done  output  1  single-cycle pulse; o_result, o_found and o_err are valid.
o_result  output  DATA_WIDTH  recovered value; held until the next accepted start.
o_found  output  1  an exact match (i_eq) was seen during the search.
o_err  output  1  flags were not one-hot during a compare cycle; sticky until the next start.

Behaviour:
- Reset:
  - Asynchronous assert, synchronous release; effective immediately, including mid-search.
  - State = IDLE; o_probe, o_result, o_busy, o_done, o_found, o_err and the bit index all 0.
- The comparator is combinational, so flags are sampled on the same cycle o_probe is valid.
- IDLE:
  - o_probe = 0.
  - i_start=1 at an edge: go to CMP, bit index = DATA_WIDTH-1, o_probe = 1<<(DATA_WIDTH-1).
  - On that same start edge, clear o_result, o_found and o_err.
- CMP: at each edge, evaluate the flags against o_probe.
  - Flags not exactly one-hot (000, or more than one set): o_err=1, go to DONE, o_result unchanged.
  - i_gt: keep the current bit, so o_result = o_probe.
  - i_eq: o_found=1 and o_result = o_probe; terminates early when SAR_EARLY_EXIT_EN is defined (see Optional Feature).
  - i_lt: drop the current bit; o_result is unchanged.
  - If the bit index is 0, or on early exit: go to DONE.
  - Otherwise: decrement the bit index and set o_probe = new o_result | (1<<new index).
- DONE:
  - o_done=1 for exactly one cycle, o_probe = 0, then go to IDLE.
- Latency:
  - N CMP cycles followed by 1 DONE cycle.
  - o_done is high in the cycle N edges after the start edge.
  - N = DATA_WIDTH without early exit; N = 1..DATA_WIDTH with early exit.
- i_start while busy (CMP or DONE) is ignored; there is no queueing.
- Target 0 is never equal to any probe. The search returns o_result=0, o_found=0, o_err=0. This is a legal outcome.
- Arithmetic is unsigned. The probe never exceeds 2^DATA_WIDTH-1, and no wrap-around is possible.

Optional Feature:
SAR_EARLY_EXIT_EN
- Defined: i_eq ends the search in that CMP cycle (o_result = o_probe, then DONE).
- Undefined: i_eq is treated as i_gt with o_found set; the search always runs all DATA_WIDTH CMP cycles.
- The final o_result is identical either way; only the latency differs.

Test Plan:
All scenarios use DATA_WIDTH=4. The bench models the comparator: flags = compare(target, o_probe).
- Target 11, macro defined -> probes 8, 12, 10, 11; o_result=11, o_found=1, o_err=0; o_done 4 edges after start.
- Target 8:
  - Macro defined -> single probe 8; o_done 1 edge after start, o_result=8, o_found=1.
  - Macro undefined -> probes 8, 12, 10, 9; o_result=8, o_found=1; o_done 4 edges after start.
- Target 0 -> probes 8, 4, 2, 1, all lt; o_result=0, o_found=0, o_err=0. Target 15 -> probes 8, 12, 14, 15; o_result=15, o_found=1.
- Bench forces flags 000 on the first CMP cycle -> o_err=1; o_done 1 edge after start; o_result=0. A following start clears o_err.
- Robustness:
  - i_start pulsed during CMP -> ignored; the result matches an uninterrupted search.
  - i_rst_n low during the 2nd CMP cycle -> all outputs 0 immediately, with no clock edge needed.
  - After release, a new start with target 5 -> o_result=5.
